// File: rtl/if_stage.sv
// Fetch stage and IF/ID pipeline register: PC, next-PC select, and
// the fetched instruction with its PC+4 latched for the D stage.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [1:0]  npc_sel,
    input  logic        br_ne,
    input  logic        co,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc4_d,
    output logic [31:0] pc8_d
);

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d_n;
    logic [31:0] pc4_q, pc4_d_n;

    logic [31:0] pc_seq;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic        br_taken;

    assign pc_seq   = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_tgt   = pc4_q + br_off;
    assign j_tgt    = {pc4_q[31:28], instr_q[25:0], 2'b00};
    // Misaligned jr targets are silently truncated to a word boundary.
    assign jr_tgt   = jr_addr & ~32'h0000_0003;
    assign br_taken = co ^ br_ne;

    always_comb begin
        pc_d      = pc_q;
        instr_d_n = instr_q;
        pc4_d_n   = pc4_q;
        if (!stall) begin
            instr_d_n = instr_f;
            pc4_d_n   = pc_seq;
            case (npc_sel_e'(npc_sel))
                NPC_BR:  pc_d = br_taken ? br_tgt : pc_seq;
                NPC_J:   pc_d = j_tgt;
                NPC_JR:  pc_d = jr_tgt;
                default: pc_d = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d_n;
            pc4_q   <= pc4_d_n;
        end
    end

    assign pc_f    = pc_q;
    assign instr_d = instr_q;
    assign pc4_d   = pc4_q;
    assign pc8_d   = pc4_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected PC/IF-ID states are queued
// when a step is driven and compared after the following clock edge.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr_f;
    logic [1:0]  npc_sel;
    logic        br_ne;
    logic        co;
    logic [31:0] jr_addr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic [31:0] pc8_d;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];

    if_stage #(.PC_RESET(32'h0000_3000)) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .instr_f (instr_f),
        .npc_sel (npc_sel),
        .br_ne   (br_ne),
        .co      (co),
        .jr_addr (jr_addr),
        .pc_f    (pc_f),
        .instr_d (instr_d),
        .pc4_d   (pc4_d),
        .pc8_d   (pc8_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] pc4);
        exp_t e;
        e.tag = tag;
        e.pc  = pc;
        e.ins = ins;
        e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".pc_f"},    pc_f,    e.pc);
            chk({e.tag, ".instr_d"}, instr_d, e.ins);
            chk({e.tag, ".pc4_d"},   pc4_d,   e.pc4);
            chk({e.tag, ".pc8_d"},   pc8_d,   e.pc4 + 32'd4);
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, check it.
    task automatic step(input string tag, input logic st,
                        input logic [1:0] sel, input logic bne,
                        input logic c, input logic [31:0] jra,
                        input logic [31:0] ins_in, input logic [31:0] e_pc,
                        input logic [31:0] e_ins, input logic [31:0] e_pc4);
        stall   = st;
        npc_sel = sel;
        br_ne   = bne;
        co      = c;
        jr_addr = jra;
        instr_f = ins_in;
        push(tag, e_pc, e_ins, e_pc4);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        instr_f = 32'd0;
        npc_sel = 2'b00;
        br_ne   = 1'b0;
        co      = 1'b0;
        jr_addr = 32'd0;
        #12;
        push("reset", 32'h3000, 32'h0, 32'h0);
        pop_check();
        reset = 1'b0;

        step("free1", 0, 2'b00, 0, 0, 0, 32'h0000_0000,
             32'h3004, 32'h0000_0000, 32'h3004);
        step("free2", 0, 2'b00, 0, 0, 0, 32'h1000_0003,
             32'h3008, 32'h1000_0003, 32'h3008);
        step("beq_tk", 0, 2'b01, 0, 1, 0, 32'hAAAA_0001,
             32'h3014, 32'hAAAA_0001, 32'h300C);
        step("seq_a", 0, 2'b00, 0, 0, 0, 32'h1000_0003,
             32'h3018, 32'h1000_0003, 32'h3018);
        step("beq_nt", 0, 2'b01, 0, 0, 0, 32'h1400_FFFF,
             32'h301C, 32'h1400_FFFF, 32'h301C);
        step("bne_neg", 0, 2'b01, 1, 0, 0, 32'hBBBB_0002,
             32'h3018, 32'hBBBB_0002, 32'h3020);
        step("seq_b", 0, 2'b00, 0, 0, 0, 32'h0800_0C05,
             32'h301C, 32'h0800_0C05, 32'h301C);
        step("jump", 0, 2'b10, 0, 1, 32'h1234_5678, 32'hCCCC_0003,
             32'h3014, 32'hCCCC_0003, 32'h3020);
        step("seq_c", 0, 2'b00, 0, 0, 0, 32'h0000_0008,
             32'h3018, 32'h0000_0008, 32'h3018);
        step("jr", 0, 2'b11, 0, 0, 32'h0000_3023, 32'hDDDD_0004,
             32'h3020, 32'hDDDD_0004, 32'h301C);
        step("seq_noise", 0, 2'b00, 1, 1, 32'hFFFF_FFFF, 32'h1000_0002,
             32'h3024, 32'h1000_0002, 32'h3024);

        step("stall1", 1, 2'b01, 0, 1, 0, 32'hEEEE_0005,
             32'h3024, 32'h1000_0002, 32'h3024);
        step("stall2", 1, 2'b01, 0, 0, 0, 32'hEEEE_0005,
             32'h3024, 32'h1000_0002, 32'h3024);
        step("stall3", 1, 2'b01, 0, 1, 0, 32'hEEEE_0005,
             32'h3024, 32'h1000_0002, 32'h3024);
        step("rel_nt", 0, 2'b01, 0, 0, 0, 32'hEEEE_0005,
             32'h3028, 32'hEEEE_0005, 32'h3028);

        step("seq_d", 0, 2'b00, 0, 0, 0, 32'h1000_0004,
             32'h302C, 32'h1000_0004, 32'h302C);
        step("stall4", 1, 2'b01, 0, 0, 0, 32'h1111_0006,
             32'h302C, 32'h1000_0004, 32'h302C);
        step("rel_tk", 0, 2'b01, 0, 1, 0, 32'h1111_0006,
             32'h303C, 32'h1111_0006, 32'h3030);

        step("seq_e", 0, 2'b00, 0, 0, 0, 32'h0000_0008,
             32'h3040, 32'h0000_0008, 32'h3040);
        step("jr_top", 0, 2'b11, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000,
             32'hFFFF_FFFC, 32'h0000_0000, 32'h3044);
        step("wrap", 0, 2'b00, 0, 0, 0, 32'h0000_0000,
             32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        step("seq_f", 0, 2'b00, 0, 0, 0, 32'h0800_0C05,
             32'h0000_0004, 32'h0800_0C05, 32'h0000_0004);

        // Jump sits in D; reset arrives between edges and must win at once.
        npc_sel = 2'b10;
        instr_f = 32'h9999_0007;
        #3;
        reset = 1'b1;
        #1;
        push("async_rst", 32'h3000, 32'h0, 32'h0);
        pop_check();
        #1;
        reset   = 1'b0;
        npc_sel = 2'b00;
        step("post_rst", 0, 2'b00, 0, 0, 0, 32'h0000_0000,
             32'h3004, 32'h0000_0000, 32'h3004);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
